// File: rtl/pwm_timebase_counter.sv
// PWM timebase: prescaled UP / DOWN / UP_DOWN counter with phase load and a registered sync output.
// Define PWM_TB_SHADOW_EN to shadow the period register so P_active only changes at reload points.
module pwm_timebase_counter #(
   parameter int WIDTH = 16,
   parameter int PRE_W = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic [1:0]       i_mode,
   input  logic [PRE_W-1:0] i_prescale,
   input  logic [WIDTH-1:0] i_period,
   input  logic             i_period_wr,
   input  logic [WIDTH-1:0] i_phase,
   input  logic             i_phase_dir,
   input  logic             i_phase_en,
   input  logic             i_sync_in,
   input  logic [2:0]       i_sync_sel,
   input  logic [WIDTH-1:0] i_compare_b,
   input  logic             i_sync_en,
   output logic             o_sync,
   output logic [WIDTH-1:0] o_counter,
   output logic [WIDTH-1:0] o_counter_next,
   output logic             o_dir,
   output logic             o_zero,
   output logic             o_period_match
);

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_UD   = 2'b11;
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             sync_q, sync_d;

   logic [WIDTH-1:0] p_act;
   logic [WIDTH-1:0] p_act_nxt;
   logic [WIDTH-1:0] reload_val;
   logic             tick;
   logic             phase_ld;
   logic             upd;
   logic             reload;
   logic             sync_evt;

`ifdef PWM_TB_SHADOW_EN
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] pact_q, pact_d;

   assign p_act      = pact_q;
   assign p_act_nxt  = pact_d;
   // A DOWN reload lands on the value that is becoming P_active, i.e. the shadow.
   assign reload_val = shadow_q;

   always_comb begin
      shadow_d = i_period_wr ? i_period : shadow_q;
      pact_d   = pact_q;
      if (i_mode == MODE_OFF || reload) begin
         pact_d = shadow_q;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         shadow_q <= '0;
         pact_q   <= '0;
      end else begin
         shadow_q <= shadow_d;
         pact_q   <= pact_d;
      end
   end
`else
   logic unused_sigs;

   assign unused_sigs = i_period_wr | reload;
   assign p_act       = i_period;
   assign p_act_nxt   = i_period;
   assign reload_val  = i_period;
`endif

   always_comb begin
      tick     = i_en && (pre_q == i_prescale);
      phase_ld = i_en && i_phase_en && i_sync_in && (i_mode != MODE_OFF);
      upd      = phase_ld || (tick && (i_mode != MODE_OFF));

      pre_d = pre_q;
      if (phase_ld) begin
         pre_d = '0;
      end else if (i_en) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end

      cnt_d  = cnt_q;
      dir_d  = dir_q;
      reload = 1'b0;
      if (phase_ld) begin
         cnt_d = (i_phase > p_act) ? p_act : i_phase;
         case (i_mode)
            MODE_UP:   dir_d = 1'b0;
            MODE_DOWN: dir_d = 1'b1;
            default:   dir_d = i_phase_dir;
         endcase
      end else if (upd) begin
         // An out-of-range count (period shrunk while stopped) restarts from zero going up.
         if (cnt_q > p_act) begin
            cnt_d = '0;
            dir_d = 1'b0;
         end else begin
            case (i_mode)
               MODE_UP: begin
                  dir_d = 1'b0;
                  if (cnt_q == p_act) begin
                     cnt_d  = '0;
                     reload = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               MODE_DOWN: begin
                  dir_d = 1'b1;
                  if (cnt_q == '0) begin
                     cnt_d  = reload_val;
                     reload = 1'b1;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               MODE_UD: begin
                  if (p_act == '0) begin
                     cnt_d  = '0;
                     dir_d  = 1'b0;
                     reload = 1'b1;
                  end else if (!dir_q) begin
                     if (cnt_q == p_act) begin
                        cnt_d = p_act - 1'b1;
                        dir_d = 1'b1;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end else begin
                     if (cnt_q == '0) begin
                        cnt_d  = CNT_ONE;
                        dir_d  = 1'b0;
                        reload = 1'b1;
                     end else begin
                        cnt_d = cnt_q - 1'b1;
                     end
                  end
               end
               default: begin
                  cnt_d = cnt_q;
               end
            endcase
         end
      end
   end

   always_comb begin
      case (i_sync_sel)
         3'b000:  sync_evt = (cnt_d == '0);
         3'b001:  sync_evt = (cnt_d == p_act_nxt);
         3'b010:  sync_evt = (cnt_d == i_compare_b) && !dir_d;
         3'b011:  sync_evt = (cnt_d == i_compare_b) && dir_d;
         default: sync_evt = 1'b0;
      endcase

      sync_d = 1'b0;
      if (i_sync_sel == 3'b100) begin
         sync_d = i_en && i_sync_in;
      end else if (upd) begin
         sync_d = sync_evt;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q  <= '0;
         dir_q  <= 1'b0;
         pre_q  <= '0;
         sync_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         pre_q  <= pre_d;
         sync_q <= sync_d;
      end
   end

   assign o_counter      = cnt_q;
   assign o_counter_next = cnt_d;
   assign o_dir          = dir_q;
   assign o_zero         = (cnt_q == '0);
   assign o_period_match = (cnt_q == p_act);
   assign o_sync         = i_sync_en & sync_q;

endmodule

// File: tb/tb_pwm_timebase_counter.sv
// Testbench for pwm_timebase_counter: directed scenarios plus randomized traffic against a behavioural model.
module tb_pwm_timebase_counter;

   localparam int WIDTH = 16;
   localparam int PRE_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en;
   logic [1:0]       mode;
   logic [PRE_W-1:0] prescale;
   logic [WIDTH-1:0] period;
   logic             period_wr;
   logic [WIDTH-1:0] phase;
   logic             phase_dir;
   logic             phase_en;
   logic             sync_in;
   logic [2:0]       sync_sel;
   logic [WIDTH-1:0] compare_b;
   logic             sync_en;
   logic             o_sync;
   logic [WIDTH-1:0] o_counter;
   logic [WIDTH-1:0] o_counter_next;
   logic             o_dir;
   logic             o_zero;
   logic             o_period_match;

   int total = 0;
   int bad   = 0;

   int m_cnt, m_dir, m_pre, m_sync, m_shadow, m_pact;
   int n_cnt, n_dir, n_pre, n_sync, n_shadow, n_pact;

   pwm_timebase_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_en           (en),
      .i_mode         (mode),
      .i_prescale     (prescale),
      .i_period       (period),
      .i_period_wr    (period_wr),
      .i_phase        (phase),
      .i_phase_dir    (phase_dir),
      .i_phase_en     (phase_en),
      .i_sync_in      (sync_in),
      .i_sync_sel     (sync_sel),
      .i_compare_b    (compare_b),
      .i_sync_en      (sync_en),
      .o_sync         (o_sync),
      .o_counter      (o_counter),
      .o_counter_next (o_counter_next),
      .o_dir          (o_dir),
      .o_zero         (o_zero),
      .o_period_match (o_period_match)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int pact_now();
`ifdef PWM_TB_SHADOW_EN
      return m_pact;
`else
      return int'(period);
`endif
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_dir = 0; m_pre = 0; m_sync = 0; m_shadow = 0; m_pact = 0;
   endtask

   // Next state from the counting rules, using plain integer arithmetic.
   task automatic model_next();
      int  p, tgt, s, pnext;
      bit  tick, pl, upd, reload, ev;
      p = pact_now();
`ifdef PWM_TB_SHADOW_EN
      tgt = m_shadow;
`else
      tgt = int'(period);
`endif
      tick   = en && (m_pre == int'(prescale));
      pl     = en && phase_en && sync_in && (mode != 2'd0);
      upd    = pl || (tick && mode != 2'd0);
      reload = 1'b0;
      n_cnt  = m_cnt;
      n_dir  = m_dir;
      if (pl) begin
         n_cnt = (int'(phase) < p) ? int'(phase) : p;
         n_dir = (mode == 2'd1) ? 0 : (mode == 2'd2) ? 1 : int'(phase_dir);
      end else if (upd) begin
         if (m_cnt > p) begin
            n_cnt = 0; n_dir = 0;
         end else if (mode == 2'd1) begin
            n_cnt  = (m_cnt + 1) % (p + 1);
            n_dir  = 0;
            reload = (n_cnt == 0);
         end else if (mode == 2'd2) begin
            n_dir  = 1;
            reload = (m_cnt == 0);
            n_cnt  = (m_cnt == 0) ? tgt : m_cnt - 1;
         end else if (p == 0) begin
            n_cnt = 0; n_dir = 0; reload = 1'b1;
         end else begin
            s = (m_dir != 0) ? -1 : 1;
            if (m_cnt + s > p || m_cnt + s < 0) begin
               s      = -s;
               n_dir  = (m_dir != 0) ? 0 : 1;
               reload = (m_dir != 0);
            end
            n_cnt = m_cnt + s;
         end
      end
      if (pl) n_pre = 0;
      else if (en) n_pre = tick ? 0 : (m_pre + 1) % (1 << PRE_W);
      else n_pre = m_pre;
      n_shadow = period_wr ? int'(period) : m_shadow;
      n_pact   = (mode == 2'd0 || reload) ? m_shadow : m_pact;
`ifdef PWM_TB_SHADOW_EN
      pnext = n_pact;
`else
      pnext = int'(period);
`endif
      case (sync_sel)
         3'd0:    ev = (n_cnt == 0);
         3'd1:    ev = (n_cnt == pnext);
         3'd2:    ev = (n_cnt == int'(compare_b)) && (n_dir == 0);
         3'd3:    ev = (n_cnt == int'(compare_b)) && (n_dir == 1);
         default: ev = 1'b0;
      endcase
      if (sync_sel == 3'd4) n_sync = (en && sync_in) ? 1 : 0;
      else if (upd) n_sync = ev ? 1 : 0;
      else n_sync = 0;
   endtask

   task automatic model_commit();
      m_cnt = n_cnt; m_dir = n_dir; m_pre = n_pre; m_sync = n_sync;
      m_shadow = n_shadow; m_pact = n_pact;
   endtask

   task automatic check_outputs(input string pfx);
      chk({pfx, "_counter"}, o_counter, m_cnt);
      chk({pfx, "_dir"}, o_dir, m_dir);
      chk({pfx, "_sync"}, o_sync, (sync_en && m_sync != 0) ? 1 : 0);
      chk({pfx, "_zero"}, o_zero, (m_cnt == 0) ? 1 : 0);
      chk({pfx, "_pmatch"}, o_period_match, (m_cnt == pact_now()) ? 1 : 0);
   endtask

   task automatic cycle();
      #1;
      model_next();
      chk("counter_next", o_counter_next, n_cnt);
      @(posedge clk);
      model_commit();
      @(negedge clk);
      check_outputs("cyc");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs("rst");
      chk("rst_counter_abs", o_counter, 0);
      chk("rst_dir_abs", o_dir, 0);
      chk("rst_sync_abs", o_sync, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic program_period(input int p);
      mode      = 2'd0;
      en        = 1'b0;
      period    = WIDTH'(p);
      period_wr = 1'b1;
      cycle();
      period_wr = 1'b0;
      cycle();
      cycle();
      en = 1'b1;
   endtask

   initial begin
      int up_exp[6]   = '{1, 2, 3, 4, 0, 1};
      int up_sync[6]  = '{0, 0, 0, 0, 1, 0};
      int ud_exp[7]   = '{1, 2, 3, 2, 1, 0, 1};
      int ud_dir[7]   = '{0, 0, 0, 1, 1, 1, 0};
      int ud_sync[7]  = '{0, 0, 0, 1, 0, 0, 0};
`ifdef PWM_TB_SHADOW_EN
      int sh_exp[8]   = '{2, 3, 4, 5, 0, 1, 2, 0};
      int sh_len      = 8;
`else
      int sh_exp[8]   = '{2, 0, 1, 2, 0, 0, 0, 0};
      int sh_len      = 5;
`endif

      en = 1'b0; mode = 2'd0; prescale = '0; period = '0; period_wr = 1'b0;
      phase = '0; phase_dir = 1'b0; phase_en = 1'b0; sync_in = 1'b0;
      sync_sel = 3'd0; compare_b = '0; sync_en = 1'b1;
      #3;
      do_reset();
      chk("reset_zero", o_zero, 1);
      chk("reset_pmatch", o_period_match, 1);

      // UP count with zero sync
      program_period(4);
      mode = 2'd1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("up_seq", o_counter, up_exp[i]);
         chk("up_sync", o_sync, up_sync[i]);
      end

      // Prescaler and enable freeze
      do_reset();
      program_period(3);
      prescale = 8'd2;
      mode = 2'd1;
      for (int i = 0; i < 7; i++) cycle();
      chk("pre_after7", o_counter, 2);
      en = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      chk("pre_frozen", o_counter, 2);
      en = 1'b1;
      cycle();
      chk("pre_resume1", o_counter, 2);
      cycle();
      chk("pre_resume2", o_counter, 3);
      prescale = '0;

      // UP_DOWN with down-going compare sync
      do_reset();
      program_period(3);
      compare_b = 16'd2;
      sync_sel = 3'd3;
      mode = 2'd3;
      for (int i = 0; i < 7; i++) begin
         cycle();
         chk("ud_seq", o_counter, ud_exp[i]);
         chk("ud_dir", o_dir, ud_dir[i]);
         chk("ud_sync", o_sync, ud_sync[i]);
      end

      // Phase load and clamp
      do_reset();
      program_period(10);
      sync_sel = 3'd0;
      mode = 2'd3;
      cycle();
      cycle();
      phase = 16'd7; phase_dir = 1'b1; phase_en = 1'b1; sync_in = 1'b1;
      cycle();
      chk("phase_load", o_counter, 7);
      chk("phase_dir", o_dir, 1);
      sync_in = 1'b0;
      cycle();
      chk("phase_after", o_counter, 6);
      phase = 16'd15; sync_in = 1'b1;
      cycle();
      chk("phase_clamp", o_counter, 10);
      sync_in = 1'b0;
      cycle();
      chk("phase_clamp_after", o_counter, 9);
      phase_en = 1'b0;

      // Period write while counting
      do_reset();
      program_period(5);
      mode = 2'd1;
      cycle();
      chk("sh_start", o_counter, 1);
      period = 16'd2; period_wr = 1'b1;
      for (int i = 0; i < sh_len; i++) begin
         cycle();
         period_wr = 1'b0;
         chk("sh_seq", o_counter, sh_exp[i]);
      end

      // Asynchronous reset mid-count in DOWN mode
      do_reset();
      program_period(5);
      sync_sel = 3'd4; sync_in = 1'b1; phase_en = 1'b0;
      mode = 2'd2;
      for (int i = 0; i < 3; i++) cycle();
      chk("down_before_rst", o_counter, 3);
      chk("down_dir_before_rst", o_dir, 1);
      chk("down_sync_before_rst", o_sync, 1);
      do_reset();
      sync_in = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 59) == 0) prescale = PRE_W'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) period = WIDTH'($urandom_range(0, 12));
         if ($urandom_range(0, 49) == 0) sync_sel = 3'($urandom);
         en        = ($urandom_range(0, 9) != 0);
         period_wr = ($urandom_range(0, 19) == 0);
         phase     = WIDTH'($urandom_range(0, 15));
         phase_dir = 1'($urandom);
         phase_en  = ($urandom_range(0, 3) != 0);
         sync_in   = ($urandom_range(0, 9) == 0);
         compare_b = WIDTH'($urandom_range(0, 12));
         sync_en   = ($urandom_range(0, 7) != 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
